// File: rtl/led_pattern_reader.sv
// led_pattern_reader: steps an address through the LED pattern ROM at a fixed rate,
// latches each word onto the LEDs and flags words that are not one-hot.
module led_pattern_reader #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 4,
   parameter int LAST_ADDR   = 4095,
   parameter int STEP_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              dir,
   input  logic              err_clr,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] led,
   output logic              led_stb,
   output logic              pattern_err
);
   localparam int PW = $clog2(STEP_CYCLES);
   localparam logic [PW-1:0] PS_END = PW'(STEP_CYCLES - 3);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(LAST_ADDR);
   localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, FETCH = 2'd2, LATCH = 2'd3;
   logic [1:0] state, state_next;
   logic [PW-1:0] prescaler;
   logic latch, bad;
   assign latch  = state == LATCH;
   assign rom_en = state == FETCH;
   assign bad    = $countones(rom_data) != 1;
   // FETCH and LATCH take one cycle each, so COUNT covers the rest of the step period
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = run ? COUNT : IDLE;
         COUNT:   state_next = !run ? IDLE : (prescaler == PS_END ? FETCH : COUNT);
         FETCH:   state_next = LATCH;
         default: state_next = run ? COUNT : IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         prescaler   <= '0;
         rom_addr    <= '0;
         led         <= '0;
         led_stb     <= 1'b0;
         pattern_err <= 1'b0;
      end else begin
         state     <= state_next;
         prescaler <= (state == COUNT && run && prescaler != PS_END) ? prescaler + 1'b1 : '0;
         led_stb   <= latch;
         if (latch) begin
            led      <= rom_data;
            rom_addr <= dir ? (rom_addr == '0 ? A_LAST : rom_addr - 1'b1)
                            : (rom_addr == A_LAST ? '0 : rom_addr + 1'b1);
         end
         // a bad word in the same cycle as err_clr keeps the flag set
         if (latch && bad) pattern_err <= 1'b1;
         else if (err_clr) pattern_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_led_pattern_reader.sv
// tb_led_pattern_reader: directed checks of the pattern reader with STEP_CYCLES=4 (instance a)
// and the minimum STEP_CYCLES=3 (instance b), each fed by a 1-cycle-latency ROM model.
module tb_led_pattern_reader;
   logic clk = 1'b0, rst_n = 1'b0;
   logic run_a = 1'b0, dir_a = 1'b0, clr_a = 1'b0, run_b = 1'b0;
   logic en_a, en_b, stb_a, stb_b, err_a, err_b;
   logic [11:0] addr_a, addr_b, last_a;
   logic [3:0] data_a, data_b, led_a, led_b;
   logic [3:0] rom [8];
   int vectors = 0, errors = 0, n;
   always #5 clk = ~clk;
   led_pattern_reader #(.ADDR_W(12), .DATA_W(4), .LAST_ADDR(7), .STEP_CYCLES(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .run(run_a), .dir(dir_a), .err_clr(clr_a), .rom_en(en_a),
      .rom_addr(addr_a), .rom_data(data_a), .led(led_a), .led_stb(stb_a), .pattern_err(err_a));
   led_pattern_reader #(.ADDR_W(12), .DATA_W(4), .LAST_ADDR(7), .STEP_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .run(run_b), .dir(1'b0), .err_clr(1'b0), .rom_en(en_b),
      .rom_addr(addr_b), .rom_data(data_b), .led(led_b), .led_stb(stb_b), .pattern_err(err_b));
   always @(posedge clk) begin
      if (en_a) begin
         data_a <= rom[addr_a[2:0]];
         last_a <= addr_a;
      end
      if (en_b) data_b <= rom[addr_b[2:0]];
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_stb(input bit b, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!(b ? stb_b : stb_a) && cnt < 40);
   endtask
   task automatic wait_fetch();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!en_a && c < 40);
      check("fetch_seen", 32'(en_a), 32'd1);
   endtask
   task automatic do_reset(input logic d);
      @(negedge clk);
      rst_n = 1'b0;
      run_a = 1'b0;
      dir_a = d;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_a = 1'b1;
   endtask
   initial begin
      rom = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8};
      repeat (3) @(negedge clk);
      check("rst_led", 32'(led_a), 32'd0);
      check("rst_en", 32'(en_a), 32'd0);
      check("rst_addr", 32'(addr_a), 32'd0);
      check("rst_stb", 32'(stb_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      // forward walk with wrap
      rst_n = 1'b1;
      run_a = 1'b1;
      for (int k = 0; k < 9; k++) begin
         wait_stb(1'b0, n);
         check($sformatf("fwd_gap%0d", k), 32'(n), k == 0 ? 32'd5 : 32'd4);
         check($sformatf("fwd_addr%0d", k), 32'(last_a), 32'(k % 8));
         check($sformatf("fwd_led%0d", k), 32'(led_a), 32'(rom[k % 8]));
         check($sformatf("fwd_next%0d", k), 32'(addr_a), 32'((k + 1) % 8));
      end
      check("fwd_err", 32'(err_a), 32'd0);
      // backward walk wrapping 0 -> 7
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         wait_stb(1'b0, n);
         check($sformatf("rev_addr%0d", k), 32'(last_a), k == 0 ? 32'd0 : 32'(8 - k));
         check($sformatf("rev_led%0d", k), 32'(led_a), k == 0 ? 32'd1 : 32'(rom[8 - k]));
      end
      // stop during fetch of address 2, then resume at 3
      do_reset(1'b0);
      repeat (2) wait_stb(1'b0, n);
      wait_fetch();
      check("stop_fetch_addr", 32'(addr_a), 32'd2);
      run_a = 1'b0;
      wait_stb(1'b0, n);
      check("stop_gap", 32'(n), 32'd2);
      check("stop_led", 32'(led_a), 32'd4);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         n += int'(en_a) + int'(stb_a);
      end
      check("stop_quiet", 32'(n), 32'd0);
      run_a = 1'b1;
      wait_stb(1'b0, n);
      check("resume_gap", 32'(n), 32'd5);
      check("resume_addr", 32'(last_a), 32'd3);
      check("resume_led", 32'(led_a), 32'd8);
      // bad words at addresses 5 and 6
      rom[5] = 4'h3;
      rom[6] = 4'h3;
      wait_stb(1'b0, n);
      check("err_before", 32'(err_a), 32'd0);
      wait_stb(1'b0, n);
      check("bad_led", 32'(led_a), 32'h3);
      check("err_set", 32'(err_a), 32'd1);
      wait_fetch();
      @(negedge clk);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clr_bad_stb", 32'(stb_a), 32'd1);
      check("clr_bad_err", 32'(err_a), 32'd1);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clr_alone", 32'(err_a), 32'd0);
      rom[5] = 4'd2;
      rom[6] = 4'd4;
      // asynchronous reset during fetch
      wait_fetch();
      #1 rst_n = 1'b0;
      #1;
      check("arst_led", 32'(led_a), 32'd0);
      check("arst_en", 32'(en_a), 32'd0);
      check("arst_addr", 32'(addr_a), 32'd0);
      n = 0;
      repeat (3) begin
         @(negedge clk);
         n += int'(stb_a);
      end
      check("arst_nostb", 32'(n), 32'd0);
      rst_n = 1'b1;
      wait_fetch();
      check("arst_first_addr", 32'(addr_a), 32'd0);
      wait_stb(1'b0, n);
      check("arst_first_led", 32'(led_a), 32'd1);
      // minimum step period on instance b
      run_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_stb(1'b1, n);
         check($sformatf("min_gap%0d", k), 32'(n), k == 0 ? 32'd4 : 32'd3);
         check($sformatf("min_led%0d", k), 32'(led_b), 32'(rom[k % 8]));
      end
      check("min_err", 32'(err_b), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
